// File: rtl/text_line_streamer.sv
// text_line_streamer
//
// Streams one line of text as individual characters.
// A request names a line. The line table returns that line's {length, start}
// entry, where the length is counted in memory words. The block then fetches
// each packed word from character memory. It emits the characters MSB-first on
// a valid/ready stream and marks the final character with ch_last.
//
// Build option: defining TEXT_LINE_STREAMER_NEWLINE_EN appends a 0x0A character
// to every line. That newline carries ch_last, so an empty line still emits one
// newline. The default build emits only the characters held in memory.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   req_valid    line request valid (accepted only while req_ready=1)
//   req_ready    high in IDLE only
//   req_line     requested line index
//   abort        drop the current line and return to IDLE (no done, no last)
//   tbl_line     line-table lookup index (the latched request)
//   tbl_entry    combinational table result {len, start}
//   mem_addr     character-memory word address, (start + word_cnt) mod 2^ADDR_W
//   mem_data     combinational memory word
//   ch_valid     character valid
//   ch_ready     downstream accepts the character
//   ch_data      character, zero while ch_valid=0
//   ch_last      final character of the line
//   done         one-cycle pulse after the final handshake of a line
//   dbg_state    current FSM state (0 IDLE, 1 LOOKUP, 2 FETCH, 3 EMIT)
//
// Handshake: a character transfers on a rising edge where ch_valid && ch_ready
// && !abort. While ch_valid is high and ch_ready is low, ch_data and ch_last
// hold. ch_valid never drops without a transfer except on abort or rst.
module text_line_streamer #(
    parameter int CHAR_W         = 8,
    parameter int CHARS_PER_WORD = 2,
    parameter int ADDR_W         = 9,
    parameter int LEN_W          = 9,
    parameter int LINE_W         = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [LINE_W-1:0]                req_line,
    input  logic                             abort,
    output logic [LINE_W-1:0]                tbl_line,
    input  logic [LEN_W+ADDR_W-1:0]          tbl_entry,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [CHAR_W*CHARS_PER_WORD-1:0] mem_data,
    output logic                             ch_valid,
    input  logic                             ch_ready,
    output logic [CHAR_W-1:0]                ch_data,
    output logic                             ch_last,
    output logic                             done,
    output logic [1:0]                       dbg_state
);

`ifdef TEXT_LINE_STREAMER_NEWLINE_EN
    localparam bit NL_EN = 1'b1;
`else
    localparam bit NL_EN = 1'b0;
`endif

    localparam int WORD_W = CHAR_W * CHARS_PER_WORD;
    localparam int IDX_W  = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FETCH  = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    char_idx_q, char_idx_d;
    logic                nl_q, nl_d;     // emitting the trailing newline
    logic                done_q, done_d;

    logic [LEN_W-1:0]    tbl_len;
    logic [ADDR_W-1:0]   tbl_start;
    logic                handshake;
    logic                last_char;
    logic                last_word;
    logic                word_end;
    logic                line_end;

    assign tbl_len   = tbl_entry[LEN_W+ADDR_W-1 -: LEN_W];
    assign tbl_start = tbl_entry[ADDR_W-1:0];

    // abort wins over a simultaneous handshake
    assign handshake = (state_q == S_EMIT) && ch_ready && !abort;
    assign last_char = (char_idx_q == LAST_IDX);
    // Compare one bit wider so word_cnt+1 cannot wrap at the maximum length
    assign last_word = ({1'b0, word_cnt_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    assign word_end  = handshake && !nl_q && last_char;
    assign line_end  = NL_EN ? (handshake && nl_q) : (word_end && last_word);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            len_q      <= '0;
            start_q    <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            char_idx_q <= '0;
            nl_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            len_q      <= len_d;
            start_q    <= start_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            char_idx_q <= char_idx_d;
            nl_q       <= nl_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (tbl_len == '0) state_d = NL_EN ? S_EMIT : S_IDLE;
                else               state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (line_end)                    state_d = S_IDLE;
                else if (word_end && !last_word) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && abort) state_d = S_IDLE;
    end

    // Datapath next values
    always_comb begin
        line_d     = line_q;
        len_d      = len_q;
        start_d    = start_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        char_idx_d = char_idx_q;
        nl_d       = nl_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) line_d = req_line;
            end
            S_LOOKUP: begin
                len_d      = tbl_len;
                start_d    = tbl_start;
                word_cnt_d = '0;
                if ((tbl_len == '0) && !abort) begin
                    if (NL_EN) nl_d   = 1'b1;
                    else       done_d = 1'b1;
                end
            end
            S_FETCH: begin
                word_d     = mem_data;
                char_idx_d = '0;
            end
            S_EMIT: begin
                if (handshake) begin
                    // Shift so the next character is always in the MSBs
                    word_d     = word_q << CHAR_W;
                    char_idx_d = char_idx_q + IDX_W'(1);
                    if (word_end && !last_word) word_cnt_d = word_cnt_q + LEN_W'(1);
                    if (word_end && last_word && NL_EN) nl_d = 1'b1;
                    if (line_end) done_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (state_d == S_IDLE) nl_d = 1'b0;
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == S_IDLE);
        ch_valid  = (state_q == S_EMIT);
        ch_data   = '0;
        ch_last   = 1'b0;
        if (state_q == S_EMIT) begin
            if (nl_q) begin
                ch_data = CHAR_W'(8'h0A);
                ch_last = 1'b1;
            end else begin
                ch_data = word_q[WORD_W-1 -: CHAR_W];
                ch_last = !NL_EN && last_char && last_word;
            end
        end
    end

    assign tbl_line  = line_q;
    // Sum is taken modulo 2^ADDR_W, so a line may wrap past the top of memory
    assign mem_addr  = start_q + ADDR_W'(word_cnt_q);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_text_line_streamer.sv
module tb_text_line_streamer;

    localparam int CHAR_W = 8;
    localparam int CPW    = 2;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 9;
    localparam int LINE_W = 8;
`ifdef TEXT_LINE_STREAMER_NEWLINE_EN
    localparam int NL = 1;
`else
    localparam int NL = 0;
`endif

    logic                     clk;
    logic                     rst;
    logic                     req_valid;
    logic                     req_ready;
    logic [LINE_W-1:0]        req_line;
    logic                     abort;
    logic [LINE_W-1:0]        tbl_line;
    logic [LEN_W+ADDR_W-1:0]  tbl_entry;
    logic [ADDR_W-1:0]        mem_addr;
    logic [CHAR_W*CPW-1:0]    mem_data;
    logic                     ch_valid;
    logic                     ch_ready;
    logic [CHAR_W-1:0]        ch_data;
    logic                     ch_last;
    logic                     done;
    logic [1:0]               dbg_state;

    // Behavioural ROM models
    logic [LEN_W+ADDR_W-1:0]  tbl [0:255];
    logic [CHAR_W*CPW-1:0]    mem [0:511];

    assign tbl_entry = tbl[tbl_line];
    assign mem_data  = mem[mem_addr];

    text_line_streamer #(
        .CHAR_W(CHAR_W), .CHARS_PER_WORD(CPW), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_line(req_line), .abort(abort), .tbl_line(tbl_line),
        .tbl_entry(tbl_entry), .mem_addr(mem_addr), .mem_data(mem_data),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .ch_last(ch_last), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard ----------------
    logic [CHAR_W:0] exp_q[$];   // {last, char}
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;          // 0 always ready, 1 toggle every 2 cycles, 2 random

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_len(input int line);
        logic [LEN_W+ADDR_W-1:0] e;
        e = tbl[line];
        return int'(e[LEN_W+ADDR_W-1 -: LEN_W]);
    endfunction

    // Reference model: expand a line into its character stream
    task automatic push_line(input int line);
        logic [LEN_W+ADDR_W-1:0] e;
        logic [CHAR_W*CPW-1:0]   w;
        logic [CHAR_W-1:0]       ch;
        logic                    last;
        int len, start;
        e = tbl[line];
        len = int'(e[LEN_W+ADDR_W-1 -: LEN_W]);
        start = int'(e[ADDR_W-1:0]);
        for (int i = 0; i < len; i++) begin
            w = mem[(start + i) % 512];
            for (int c = 0; c < CPW; c++) begin
                ch = CHAR_W'(w >> (CHAR_W * (CPW - 1 - c)));
                last = (NL == 0) && (i == len - 1) && (c == CPW - 1);
                exp_q.push_back({last, ch});
            end
        end
        if (NL != 0) exp_q.push_back({1'b1, 8'h0A});
    endtask

    // Monitor: pops on every handshake, checks stall stability and done-after-last
    initial begin
        logic            stall_prev;
        logic [CHAR_W:0] stall_val;
        logic [CHAR_W:0] e;
        logic            done_due;
        stall_prev = 1'b0;
        stall_val  = '0;
        done_due   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                done_due   = 1'b0;
            end else begin
                if (done_due) check_eq("done_after_last", 32'(done), 32'd1);
                done_due = 1'b0;
                if (stall_prev) begin
                    check_eq("stall_valid_hold", 32'(ch_valid), 32'd1);
                    check_eq("stall_data_hold", 32'({ch_last, ch_data}), 32'(stall_val));
                end
                if (ch_valid && ch_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got %0h expected none (cycle %0d)",
                                 {ch_last, ch_data}, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("char", 32'({ch_last, ch_data}), 32'(e));
                    end
                    if (ch_last) done_due = 1'b1;
                end
                stall_prev = ch_valid && !ch_ready && !abort;
                stall_val  = {ch_last, ch_data};
            end
        end
    end

    // Downstream ready driver
    initial begin
        ch_ready = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0:       ch_ready = 1'b1;
                1:       ch_ready = ((cyc / 2) % 2) == 0;
                default: ch_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_ch_valid"},  32'(ch_valid),  32'd0);
        check_eq({tag, "_ch_last"},   32'(ch_last),   32'd0);
        check_eq({tag, "_done"},      32'(done),      32'd0);
        check_eq({tag, "_ch_data"},   32'(ch_data),   32'd0);
        check_eq({tag, "_tbl_line"},  32'(tbl_line),  32'd0);
        check_eq({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check_eq({tag, "_state"},     32'(dbg_state), 32'd0);
    endtask

    // Present a request, wait for acceptance; returns the accept cycle
    task automatic issue(input int line, output int a);
        int n;
        n = 0;
        req_line  = LINE_W'(line);
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_accept", 32'(req_ready), 32'd1);
        a = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    // Full line: model push, request, wait for done, optional timing checks
    task automatic run_line(input int line, input bit timed,
                            output logic [ADDR_W-1:0] addr_a, output logic [ADDR_W-1:0] addr_b);
        int a, n, first_v, len;
        len = line_len(line);
        push_line(line);
        issue(line, a);
        first_v = -1;
        n = 0;
        addr_a = '0;
        addr_b = '0;
        @(negedge clk);
        while (!done && n < 5000) begin
            if (ch_valid && first_v < 0) first_v = cyc;
            if (cyc == a + 2) addr_a = mem_addr;
            if (cyc == a + 2 + CPW + 1) addr_b = mem_addr;
            @(negedge clk);
            n++;
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        if (timed) begin
            check_eq("done_latency", 32'(cyc - a), 32'(2 + len * (CPW + 1) + NL));
            if (len > 0)
                check_eq("first_valid_latency", 32'(first_v - a), 32'd3);
            else if (NL != 0)
                check_eq("first_valid_latency_nl", 32'(first_v - a), 32'd2);
            else
                check_eq("no_valid_for_empty", 32'(first_v), 32'hFFFF_FFFF);
        end
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [ADDR_W-1:0] aa, ab;
        int a, b, n, saw_done;

        rst = 1'b1;
        req_valid = 1'b0;
        req_line = '0;
        abort = 1'b0;
        for (int i = 0; i < 256; i++) tbl[i] = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom());

        repeat (3) tick();
        @(negedge clk);
        check_reset("por");
        tick();
        rst = 1'b0;

        // Basic line
        tbl[0] = {9'd3, 9'h000};
        mem[0] = 16'h3131;
        mem[1] = 16'h3135;
        mem[2] = 16'h7320;
        ready_mode = 0;
        tick();
        run_line(0, 1'b1, aa, ab);
        check_eq("basic_addr_word0", 32'(aa), 32'h000);
        check_eq("basic_addr_word1", 32'(ab), 32'h001);

        // Backpressure on the same line
        ready_mode = 1;
        tick();
        run_line(0, 1'b0, aa, ab);
        ready_mode = 0;

        // Zero length
        tbl[5] = {9'd0, 9'h040};
        tick();
        run_line(5, 1'b1, aa, ab);

        // Address wrap
        tbl[2] = {9'd2, 9'h1FF};
        mem[9'h1FF] = 16'h4142;
        mem[0] = 16'h4344;
        tick();
        run_line(2, 1'b1, aa, ab);
        check_eq("wrap_addr_first", 32'(aa), 32'h1FF);
        check_eq("wrap_addr_second", 32'(ab), 32'h000);

        // Abort during the second character of a 3-word line
        tbl[3] = {9'd3, 9'h010};
        tick();
        push_line(3);
        issue(3, a);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_consumed_one", 32'(exp_q.size()), 32'(3 * CPW + NL - 1));
        exp_q.delete();
        @(negedge clk);
        check_eq("abort_ch_valid", 32'(ch_valid), 32'd0);
        check_eq("abort_ch_last", 32'(ch_last), 32'd0);
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        check_eq("abort_done_now", 32'(done), 32'd0);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'd0);

        // Reset in the middle of FETCH
        tbl[0] = {9'd3, 9'h000};
        mem[0] = 16'h3131;
        tick();
        push_line(0);
        issue(0, a);
        tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        @(negedge clk);
        check_reset("midrst");
        tick();
        rst = 1'b0;
        tick();
        run_line(0, 1'b1, aa, ab);

        // Request blocking: line 1 held while line 0 streams
        tbl[1] = {9'd2, 9'h020};
        tick();
        push_line(0);
        issue(0, a);
        push_line(1);
        req_line = LINE_W'(1);
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        b = cyc;
        check_eq("block_accept_cycle", 32'(b - a), 32'(2 + 3 * (CPW + 1) + NL));
        check_eq("block_done_at_accept", 32'(done), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("block_line1_done", 32'(done), 32'd1);
        check_eq("block_line1_latency", 32'(cyc - b), 32'(2 + 2 * (CPW + 1) + NL));
        check_eq("block_queue_drained", 32'(exp_q.size()), 32'd0);

        // Randomised lines with random backpressure
        for (int i = 0; i < 20; i++) begin
            tbl[10 + i] = {9'($urandom_range(0, 4)), 9'($urandom_range(0, 511))};
            ready_mode = $urandom_range(0, 2);
            tick();
            run_line(10 + i, ready_mode == 0, aa, ab);
        end

        ready_mode = 0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
